// File: rtl/mem_issue_fifo.sv
// mem_issue_fifo: in-order issue buffer feeding the memory execution pipe (pipe 3).
// Holds dispatched load/store uops with their operands in program order and
// presents the oldest one whenever pipe 3 is not busy. Presentation is the
// handshake: pipe 3 latches any valid uop shown while its busy is low.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   enq_uop     dispatched uop; push requested when enq_uop.valid
//   enq_in1     base address operand
//   enq_in2     store data operand
//   enq_ready   buffer can accept a push this cycle
//   flush       discard all entries
//   pipe_busy   pipe 3 busy
//   deq_uop     uop presented to pipe 3 (.valid marks an issue)
//   deq_in1     in1 to pipe 3
//   deq_in2     in2 to pipe 3
//   count       current occupancy
//   issued_cnt  uops issued since reset (wraps)

package mem_issue_pkg;
  typedef struct packed {
    logic        valid;
    logic [3:0]  fu_code;
    logic [1:0]  mem_type;
    logic [7:0]  tag;
    logic [31:0] imm;
  } micro_op_t;
endpackage

module mem_issue_fifo
  import mem_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  micro_op_t                enq_uop,
  input  logic [31:0]              enq_in1,
  input  logic [31:0]              enq_in2,
  output logic                     enq_ready,
  input  logic                     flush,
  input  logic                     pipe_busy,
  output micro_op_t                deq_uop,
  output logic [31:0]              deq_in1,
  output logic [31:0]              deq_in2,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              issued_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  micro_op_t   mem_uop [DEPTH];
  logic [31:0] mem_in1 [DEPTH];
  logic [31:0] mem_in2 [DEPTH];

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [AW-1:0] head_idx;
  logic [AW-1:0] tail_idx;

  logic full;
  logic empty;
  logic push;
  logic issue;

  assign head_idx = head[AW-1:0];
  assign tail_idx = tail[AW-1:0];

  assign count = tail - head;
  assign full  = (count == PW'(DEPTH));
  assign empty = (count == '0);

  assign enq_ready = reset & ~full;
  assign push      = enq_uop.valid & enq_ready & ~flush;
  assign issue     = ~empty & ~pipe_busy & ~flush;

  assign deq_uop = issue ? mem_uop[head_idx] : '0;
  assign deq_in1 = issue ? mem_in1[head_idx] : '0;
  assign deq_in2 = issue ? mem_in2[head_idx] : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      issued_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_uop[i] <= '0;
        mem_in1[i] <= '0;
        mem_in2[i] <= '0;
      end
    end else if (flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push) begin
        mem_uop[tail_idx] <= enq_uop;
        mem_in1[tail_idx] <= enq_in1;
        mem_in2[tail_idx] <= enq_in2;
        tail              <= tail + 1'b1;
      end
      if (issue) begin
        head       <= head + 1'b1;
        issued_cnt <= issued_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_issue_fifo.sv
module tb_mem_issue_fifo;
  import mem_issue_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic        clock;
  logic        reset;
  micro_op_t   enq_uop;
  logic [31:0] enq_in1;
  logic [31:0] enq_in2;
  logic        enq_ready;
  logic        flush;
  logic        pipe_busy;
  micro_op_t   deq_uop;
  logic [31:0] deq_in1;
  logic [31:0] deq_in2;
  logic [3:0]  count;
  logic [31:0] issued_cnt;

  mem_issue_fifo #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .enq_uop   (enq_uop),
    .enq_in1   (enq_in1),
    .enq_in2   (enq_in2),
    .enq_ready (enq_ready),
    .flush     (flush),
    .pipe_busy (pipe_busy),
    .deq_uop   (deq_uop),
    .deq_in1   (deq_in1),
    .deq_in2   (deq_in2),
    .count     (count),
    .issued_cnt(issued_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_pass;
  int unsigned n_total;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: a plain queue of entries.
  typedef struct {
    micro_op_t   uop;
    logic [31:0] in1;
    logic [31:0] in2;
  } entry_t;

  entry_t      mq[$];
  int unsigned m_issued;
  logic [7:0]  dut_log[$];

  always @(negedge clock) begin
    logic      exp_ready;
    logic      iss;
    micro_op_t exp_uop;
    logic [31:0] exp_in1, exp_in2;
    entry_t    e;
    if (!reset) begin
      mq.delete();
      m_issued = 0;
      exp_ready = 1'b0;
      iss = 1'b0;
    end else begin
      exp_ready = (mq.size() < DEPTH);
      iss = (mq.size() > 0) && !pipe_busy && !flush;
    end
    exp_uop = '0; exp_in1 = '0; exp_in2 = '0;
    if (iss) begin
      exp_uop = mq[0].uop; exp_in1 = mq[0].in1; exp_in2 = mq[0].in2;
    end
    chk("m_enq_ready", 64'(enq_ready), 64'(exp_ready));
    chk("m_count", 64'(count), 64'(mq.size()));
    chk("m_issued_cnt", 64'(issued_cnt), 64'(m_issued));
    chk("m_deq_uop", 64'(deq_uop), 64'(exp_uop));
    chk("m_deq_in1", 64'(deq_in1), 64'(exp_in1));
    chk("m_deq_in2", 64'(deq_in2), 64'(exp_in2));
    if (deq_uop.valid) dut_log.push_back(deq_uop.tag);
    if (reset) begin
      if (flush) mq.delete();
      else begin
        if (iss) begin
          void'(mq.pop_front());
          m_issued++;
        end
        if (enq_uop.valid && exp_ready) begin
          e.uop = enq_uop; e.in1 = enq_in1; e.in2 = enq_in2;
          mq.push_back(e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_push(input logic [7:0] tag, input logic [31:0] imm);
    enq_uop          = '0;
    enq_uop.valid    = 1'b1;
    enq_uop.fu_code  = 4'h3;
    enq_uop.mem_type = tag[0] ? 2'd1 : 2'd0;
    enq_uop.tag      = tag;
    enq_uop.imm      = imm;
    enq_in1          = 32'h1000_0000 + 32'(tag);
    enq_in2          = ~(32'(tag));
  endtask

  task automatic no_push();
    enq_uop = '0;
    enq_in1 = '0;
    enq_in2 = '0;
  endtask

  task automatic chk_log(input string name, input int unsigned first, input int unsigned n);
    chk({name, "_len"}, 64'(dut_log.size()), 64'(n));
    for (int unsigned i = 0; i < n && i < dut_log.size(); i++)
      chk(name, 64'(dut_log[i]), 64'(first + i));
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b0; flush = 1'b0; pipe_busy = 1'b0;
    set_push(8'd55, 32'd0);

    // Reset held with a push request pending.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_ready", 64'(enq_ready), 64'd0);
      chk("rst_deq_valid", 64'(deq_uop.valid), 64'd0);
    end
    no_push();
    reset = 1'b1;
    #1;
    chk("rel_ready", 64'(enq_ready), 64'd1);
    step();

    // Ordering: imm 0,4,8 issue in order, one issue per non-busy cycle.
    pipe_busy = 1'b1;
    set_push(8'd0, 32'd0); step();
    set_push(8'd1, 32'd4); step();
    set_push(8'd2, 32'd8); step();
    no_push();
    for (int i = 0; i < 3; i++) begin
      pipe_busy = 1'b0;
      #1;
      chk("ord_imm", 64'(deq_uop.imm), 64'(4 * i));
      chk("ord_valid", 64'(deq_uop.valid), 64'd1);
      step();
      pipe_busy = 1'b1;
      step();
    end
    chk("ord_issued", 64'(issued_cnt), 64'd3);
    chk("ord_model_issued", 64'(m_issued), 64'd3);
    chk("ord_count", 64'(count), 64'd0);
    dut_log.delete();

    // Full and pointer wrap.
    for (int i = 0; i < 8; i++) begin
      set_push(8'(i), 32'(4 * i)); step();
    end
    chk("full_count", 64'(count), 64'd8);
    chk("full_ready", 64'(enq_ready), 64'd0);
    set_push(8'd99, 32'd0); step();
    chk("full_ninth_ignored", 64'(count), 64'd8);
    no_push();
    pipe_busy = 1'b0;
    step(); step(); step();
    pipe_busy = 1'b1;
    chk("wrap_count5", 64'(count), 64'd5);
    for (int i = 8; i < 11; i++) begin
      set_push(8'(i), 32'(4 * i)); step();
    end
    no_push();
    pipe_busy = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk_log("wrap_tag", 0, 11);
    chk("wrap_issued", 64'(issued_cnt), 64'd14);
    chk("wrap_model_issued", 64'(m_issued), 64'd14);
    dut_log.delete();

    // Simultaneous push and issue at count=4.
    pipe_busy = 1'b1;
    for (int i = 20; i < 24; i++) begin
      set_push(8'(i), 32'(4 * i)); step();
    end
    pipe_busy = 1'b0;
    for (int i = 24; i < 29; i++) begin
      set_push(8'(i), 32'(4 * i)); step();
      chk("sim_count", 64'(count), 64'd4);
    end
    no_push();
    chk_log("sim_tag", 20, 5);
    for (int i = 0; i < 5; i++) step();
    chk("sim_issued", 64'(issued_cnt), 64'd23);
    dut_log.delete();

    // Flush with a concurrent push and pipe idle.
    pipe_busy = 1'b1;
    for (int i = 30; i < 35; i++) begin
      set_push(8'(i), 32'(4 * i)); step();
    end
    chk("fl_count5", 64'(count), 64'd5);
    flush = 1'b1; pipe_busy = 1'b0; set_push(8'd77, 32'd0);
    #1;
    chk("fl_deq_valid", 64'(deq_uop.valid), 64'd0);
    step();
    flush = 1'b0; no_push();
    chk("fl_count0", 64'(count), 64'd0);
    chk("fl_issued", 64'(issued_cnt), 64'd23);
    for (int i = 0; i < 3; i++) step();
    chk("fl_no_issue", 64'(dut_log.size()), 64'd0);

    // Asynchronous reset between edges with count=6.
    pipe_busy = 1'b1;
    for (int i = 40; i < 46; i++) begin
      set_push(8'(i), 32'(4 * i)); step();
    end
    no_push();
    chk("ar_count6", 64'(count), 64'd6);
    pipe_busy = 1'b0;
    #1;
    chk("ar_pre_valid", 64'(deq_uop.valid), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("ar_count_now", 64'(count), 64'd0);
    chk("ar_deq_now", 64'(deq_uop), 64'd0);
    chk("ar_in1_now", 64'(deq_in1), 64'd0);
    chk("ar_ready_now", 64'(enq_ready), 64'd0);
    chk("ar_issued_now", 64'(issued_cnt), 64'd0);
    step();
    reset = 1'b1;
    step();
    chk("ar_count_after", 64'(count), 64'd0);
    chk("ar_issued_after", 64'(issued_cnt), 64'd0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
